// File: rtl/f_ifu.sv
// f_ifu: fetch-stage instruction fetch unit.
// Owns the architectural PC, fetches over an im_req/im_ack handshake and
// presents F_pc/F_instr/F_valid to the F/D register. A fetched word that
// cannot be handed on because of stall_F is parked in a hold register.
// Optional build macro IFU_RANGE_CHECK_EN adds an IM_LO..IM_HI range check
// to the fetch address error (alignment is always checked).
module f_ifu #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_F,
  input  logic [31:0] npc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic        F_exc_adel,
  output logic        fetch_stall
);

`ifdef IFU_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold;

  logic        w_pc_bad;
  logic        w_advance;

  // Address error detection and the combinational fetch-side outputs.
  always_comb begin
    w_pc_bad    = (r_pc[1:0] != 2'b00) ||
                  (RANGE_EN && ((r_pc < IM_LO) || (r_pc > IM_HI)));
    im_req      = (r_state == REQ) && !w_pc_bad;
    im_addr     = r_pc;
    F_pc        = r_pc;
    F_valid     = (r_state == HOLD) ||
                  ((r_state == REQ) && (w_pc_bad || im_ack));
    F_instr     = '0;
    if (F_valid) begin
      if (r_state == HOLD)
        F_instr = r_hold;
      else if (!w_pc_bad)
        F_instr = im_rdata;
    end
    F_exc_adel  = F_valid && w_pc_bad;
    fetch_stall = (r_state != BOOT) && !F_valid;
    w_advance   = F_valid && !stall_F;
  end

  // Fetch FSM: PC advance on hand-off, capture into hold register on stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= BOOT;
      r_pc    <= PC_RESET;
      r_hold  <= '0;
    end else begin
      case (r_state)
        BOOT: r_state <= REQ;
        REQ: begin
          if (w_advance) begin
            r_pc <= npc;
          end else if (F_valid) begin
            r_hold  <= F_instr;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_advance) begin
            r_pc    <= npc;
            r_state <= REQ;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

endmodule
